// File: rtl/hilo_div_unit_pkg.sv
// Shared definitions for the HI/LO divide unit: bus widths, iteration count and FSM state type.
package hilo_div_unit_pkg;

  localparam int DATA_BUS_W       = 32;
  localparam int DOUBLE_REG_BUS_W = 2 * DATA_BUS_W;
  localparam int DIV_ITER         = DATA_BUS_W;

  typedef enum logic [1:0] {
    IDLE,
    DIVZERO,
    BUSY,
    DONE
  } div_state_e;

endpackage

// File: rtl/hilo_div_unit_if.sv
// Operand/result bundle between the EX-stage pipeline and the divide unit.
interface hilo_div_unit_if
  import hilo_div_unit_pkg::*;
#(
  parameter int DATA_W = DATA_BUS_W
);

  logic                  start_i;
  logic                  signed_i;
  logic [DATA_W-1:0]     dividend_i;
  logic [DATA_W-1:0]     divisor_i;
  logic                  annul_i;
  logic                  stall_req_o;
  logic                  result_valid_o;
  logic [2*DATA_W-1:0]   wdata_o;
  logic                  w_hi_o;
  logic                  w_lo_o;

  modport master (
    output start_i, signed_i, dividend_i, divisor_i, annul_i,
    input  stall_req_o, result_valid_o, wdata_o, w_hi_o, w_lo_o
  );

  modport slave (
    input  start_i, signed_i, dividend_i, divisor_i, annul_i,
    output stall_req_o, result_valid_o, wdata_o, w_hi_o, w_lo_o
  );

endinterface

// File: rtl/hilo_div_unit_div_step.sv
// One restoring shift-subtract step: shift a dividend bit into the partial remainder and
// subtract the divisor if it fits.
module hilo_div_unit_div_step #(
  parameter int DATA_W = 32
) (
  input  logic [DATA_W-1:0] part_rem,
  input  logic              dvd_bit,
  input  logic [DATA_W-1:0] divisor,
  output logic [DATA_W-1:0] next_rem,
  output logic              q_bit
);

  logic [DATA_W:0] shifted;
  logic [DATA_W:0] trial;

  // part_rem < divisor always holds, so a non-negative trial fits back into DATA_W bits.
  always_comb begin
    shifted  = {part_rem, dvd_bit};
    trial    = shifted - {1'b0, divisor};
    q_bit    = ~trial[DATA_W];
    next_rem = q_bit ? trial[DATA_W-1:0] : shifted[DATA_W-1:0];
  end

endmodule

// File: rtl/hilo_div_unit.sv
// Iterative MIPS DIV/DIVU engine producing the {hi,lo} write word and strobes.
// Optional macro HILO_DIV_EARLY_EN: finish in one cycle when |dividend| < |divisor|.
module hilo_div_unit
  import hilo_div_unit_pkg::*;
#(
  parameter int DATA_W = DATA_BUS_W,
  parameter int CNT_W  = 6
) (
  input  logic           clk_i,
  input  logic           rst_i,
  hilo_div_unit_if.slave dv
);

  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(DATA_W - 1);

  div_state_e            state_q;
  logic [CNT_W-1:0]      cnt_q;
  logic [DATA_W-1:0]     rem_q;
  logic [DATA_W-1:0]     quo_q;
  logic [DATA_W-1:0]     dvs_q;
  logic [DATA_W-1:0]     dvd_raw_q;
  logic                  neg_quo_q;
  logic                  neg_rem_q;
  logic                  vld_q;
  logic [2*DATA_W-1:0]   wdata_q;

  logic                  dvd_neg;
  logic                  dvs_neg;
  logic [DATA_W-1:0]     dvd_mag;
  logic [DATA_W-1:0]     dvs_mag;
  logic                  accept;
  logic                  early_hit;
  logic [DATA_W-1:0]     step_rem;
  logic                  step_q;
  logic [DATA_W-1:0]     quo_next;

  function automatic logic [DATA_W-1:0] magnitude(input logic [DATA_W-1:0] x, input logic neg);
    return neg ? (~x + DATA_W'(1)) : x;
  endfunction

  // Two's-complement negate modulo 2^DATA_W; the overflow case wraps back onto itself.
  function automatic logic [DATA_W-1:0] sign_fix(input logic [DATA_W-1:0] x, input logic neg);
    logic signed [DATA_W-1:0] s;
    s = signed'(x);
    return neg ? DATA_W'(-s) : x;
  endfunction

  always_comb begin
    dvd_neg = dv.signed_i & dv.dividend_i[DATA_W-1];
    dvs_neg = dv.signed_i & dv.divisor_i[DATA_W-1];
    dvd_mag = magnitude(dv.dividend_i, dvd_neg);
    dvs_mag = magnitude(dv.divisor_i, dvs_neg);
    accept  = (state_q == IDLE) && dv.start_i && !dv.annul_i;
  end

`ifdef HILO_DIV_EARLY_EN
  assign early_hit = (dv.divisor_i != '0) && (dvd_mag < dvs_mag);
`else
  assign early_hit = 1'b0;
`endif

  hilo_div_unit_div_step #(
    .DATA_W(DATA_W)
  ) u_step (
    .part_rem (rem_q),
    .dvd_bit  (quo_q[DATA_W-1]),
    .divisor  (dvs_q),
    .next_rem (step_rem),
    .q_bit    (step_q)
  );

  assign quo_next = {quo_q[DATA_W-2:0], step_q};

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      rem_q     <= '0;
      quo_q     <= '0;
      dvs_q     <= '0;
      dvd_raw_q <= '0;
      neg_quo_q <= 1'b0;
      neg_rem_q <= 1'b0;
      vld_q     <= 1'b0;
      wdata_q   <= '0;
    end else begin
      vld_q <= 1'b0;
      if (dv.annul_i) begin
        state_q <= IDLE;
      end else begin
        unique case (state_q)
          IDLE: begin
            if (dv.start_i) begin
              rem_q     <= '0;
              quo_q     <= dvd_mag;
              dvs_q     <= dvs_mag;
              dvd_raw_q <= dv.dividend_i;
              neg_quo_q <= dvd_neg ^ dvs_neg;
              neg_rem_q <= dvd_neg;
              cnt_q     <= '0;
              if (dv.divisor_i == '0) begin
                state_q <= DIVZERO;
              end else if (early_hit) begin
                wdata_q <= {dv.dividend_i, {DATA_W{1'b0}}};
                vld_q   <= 1'b1;
                state_q <= DONE;
              end else begin
                state_q <= BUSY;
              end
            end
          end
          DIVZERO: begin
            wdata_q <= {dvd_raw_q, {DATA_W{1'b1}}};
            vld_q   <= 1'b1;
            state_q <= DONE;
          end
          BUSY: begin
            rem_q <= step_rem;
            quo_q <= quo_next;
            cnt_q <= cnt_q + CNT_W'(1);
            if (cnt_q == LAST_CNT) begin
              wdata_q <= {sign_fix(step_rem, neg_rem_q), sign_fix(quo_next, neg_quo_q)};
              vld_q   <= 1'b1;
              state_q <= DONE;
            end
          end
          DONE: begin
            state_q <= IDLE;
          end
          default: state_q <= IDLE;
        endcase
      end
    end
  end

  assign dv.stall_req_o    = accept || (state_q == DIVZERO) || (state_q == BUSY);
  assign dv.result_valid_o = vld_q && !dv.annul_i;
  assign dv.w_hi_o         = dv.result_valid_o;
  assign dv.w_lo_o         = dv.result_valid_o;
  assign dv.wdata_o        = wdata_q;

endmodule

// File: doc/hilo_div_unit.md
Name: hilo_div_unit

Overview:
- Iterative 32-bit MIPS DIV/DIVU engine in the EX stage.
- Produces the 64-bit {hi,lo} write word and the hi/lo write strobes that the MEM-stage HI/LO register consumes.
- Raises a stall request while dividing; emits exactly one result beat per accepted operation.
- Sits between the ID/EX operand registers and the EX/MEM register.

Parameters:
- DATA_W, 32, operand width; quotient and remainder are each DATA_W bits.
- CNT_W, 6, iteration counter width; must hold DATA_W.

Ports:
- clk_i  in  1  single clock; all state on rising edge.
- rst_i  in  1  synchronous, active-high reset.
- start_i  in  1  request a divide; sampled only in IDLE.
- signed_i  in  1  1 = DIV (signed), 0 = DIVU; sampled with start_i.
- dividend_i  in  DATA_W  operand rs; sampled with start_i.
- divisor_i  in  DATA_W  operand rt; sampled with start_i.
- annul_i  in  1  pipeline flush; abandons any in-flight divide.
- stall_req_o  out  1  holds the pipeline while the operation is incomplete.
- result_valid_o  out  1  one-cycle result beat.
- wdata_o  out  2*DATA_W  [63:32] = hi = remainder, [31:0] = lo = quotient.
- w_hi_o  out  1  hi write strobe; equals result_valid_o.
- w_lo_o  out  1  lo write strobe; equals result_valid_o.

Behaviour:
- Clock/reset: one clock, clk_i. Reset rst_i is synchronous, active-high.
- Reset values:
  - State = IDLE.
  - stall_req_o, result_valid_o, w_hi_o, w_lo_o = 0.
  - wdata_o = 0.
  - Internal counter and partial remainder/quotient = 0.
- States: IDLE, DIVZERO, BUSY, DONE.
- IDLE:
  - If start_i=1 and annul_i=0: latch operands, signed_i and sign flags.
  - In signed mode, convert operands to unsigned magnitudes.
  - If divisor=0, go to DIVZERO; else load counter=0 and go to BUSY.
- stall_req_o is combinational: 1 when (IDLE and start_i and !annul_i), in DIVZERO, or in BUSY; 0 in DONE.
- BUSY:
  - One restoring shift-subtract step per cycle, MSB first.
  - Exactly DATA_W cycles, then go to DONE.
- DONE:
  - Exactly one cycle with result_valid_o = w_hi_o = w_lo_o = 1.
  - Then go to IDLE unconditionally.
  - wdata_o holds its value until the next DONE; it is not cleared.
- Latency: start accepted at cycle 0, result beat at cycle DATA_W+1 (33). Back-to-back start is accepted the cycle after DONE.
- Sign fix-up, applied at the DONE register load:
  - Quotient is negated when sign(dividend) XOR sign(divisor).
  - Remainder takes the sign of the dividend.
  - Arithmetic is modulo 2^DATA_W.
- Overflow: 0x80000000 / 0xFFFFFFFF signed gives lo = 0x80000000, hi = 0. No trap.
- DIVZERO: one cycle, then DONE with hi = dividend (original, unconverted) and lo = all ones.
- annul_i:
  - In any state, next state = IDLE and result_valid_o is suppressed that cycle.
  - annul_i with start_i in IDLE: request ignored.
- rst_i mid-operation: same as annul_i, and also clears all registers.
- start_i outside IDLE is ignored. Operands are not re-sampled.

Optional Feature:
- Macro HILO_DIV_EARLY_EN.
- When defined, in IDLE: if divisor≠0 and |dividend| < |divisor| (unsigned magnitudes), skip BUSY and go straight to DONE. Result: lo = 0, hi = original dividend, latency 1.
- When undefined, all nonzero-divisor operations take the full DATA_W+1 cycles.
- Results are identical in both builds; only latency differs.

Decomposition:
- Shared package (add to the existing defines): state enum (IDLE, DIVZERO, BUSY, DONE) as a typedef; DIV_ITER = DATA_W constant; the DoubleRegBus/DataBus widths already in use.
- One natural sub-module, div_step: combinational single restoring step, (partial remainder, dividend bit, divisor) -> (next remainder, quotient bit). It is instantiated once and iterated by the FSM.

Test Plan:
- DIVU 100 / 7 -> stall_req_o high for cycles 0..32; cycle 33 single beat, wdata_o = {0x00000002, 0x0000000E}, w_hi_o = w_lo_o = 1.
- DIV -7 / 2 (0xFFFFFFF9, 0x2) -> lo = 0xFFFFFFFD, hi = 0xFFFFFFFF. DIV 0x80000000 / 0xFFFFFFFF -> lo = 0x80000000, hi = 0.
- DIVU 5 / 0 -> one DIVZERO cycle, then beat with hi = 0x5, lo = 0xFFFFFFFF at cycle 2.
- annul_i pulsed at BUSY cycle 10 -> IDLE next cycle, no result_valid_o. A new start of 9 / 3 then yields hi = 0, lo = 3 after 33 cycles.
- rst_i asserted at BUSY cycle 20 -> all outputs 0 next cycle. start_i held high across DONE -> second divide starts the cycle after DONE with exactly one beat per op.
- HILO_DIV_EARLY_EN build: DIVU 3 / 10 -> beat at cycle 1, hi = 3, lo = 0. Without the macro -> same values at cycle 33.
